div_share_ctrl: RTL

- Time-shares one 16-bit fixed-point divider among NUM_REQ requesters, such as ODE solver step units.
- Performs round-robin arbitration and a per-requester request/response handshake.
- Sequences the divider: drives its load pulse on the divider's reset/load input, waits for its ready, then captures the quotient and status flags.
- Sits between solver datapaths and the single divider instance.

---
 rtl/div_share_pkg.sv | 16 +
 rtl/div_share_ctrl_rr_arbiter.sv | 38 +++
 rtl/div_share_ctrl.sv | 122 ++++++++++++
 3 files changed

// File: rtl/div_share_pkg.sv
// Shared types and constants for the divider time-sharing controller.
// Fixed-point format: top SCALE_BITS are the scale, low MANT_BITS the mantissa.
package div_share_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  localparam int SCALE_BITS  = 3;
  localparam int MANT_BITS   = 13;
  localparam int DIV_LATENCY = 17;

endpackage

// File: rtl/div_share_ctrl_rr_arbiter.sv
// Round-robin arbiter: first set request at or after ptr, wrapping.
// Purely combinational; the caller owns the pointer register.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] gnt_idx,
  output logic                       gnt_any
);

  localparam int IW = $clog2(NUM_REQ);

  function automatic logic [IW-1:0] rot(
    input logic [IW-1:0] p,
    input int            off
  );
    int s;
    s = int'(p) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IW'(s);
  endfunction

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!gnt_any && req[rot(ptr, i)]) begin
        gnt_any           = 1'b1;
        gnt_idx           = rot(ptr, i);
        gnt[rot(ptr, i)]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/div_share_ctrl.sv
// Time-shares one fixed-point divider among NUM_REQ requesters.
// Optional watchdog in WAIT: define DIV_SHARE_TIMEOUT_EN.
module div_share_ctrl
  import div_share_pkg::*;
#(
  parameter int N              = 16,
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 40
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*N-1:0] req_dividend,
  input  logic [NUM_REQ*N-1:0] req_divisor,
  output logic [NUM_REQ-1:0]   req_accept,
  output logic [NUM_REQ-1:0]   rsp_valid,
  input  logic [NUM_REQ-1:0]   rsp_ack,
  output logic [N-1:0]         rsp_q,
  output logic                 rsp_overflow,
  output logic                 rsp_div_by_zero,
  output logic                 rsp_timeout,
  output logic                 div_load,
  output logic [N-1:0]         div_dividend,
  output logic [N-1:0]         div_divisor,
  input  logic [N-1:0]         div_q,
  input  logic                 div_ready,
  input  logic                 div_overflow,
  input  logic                 div_div_by_zero,
  output logic                 busy
);

  localparam int IW = $clog2(NUM_REQ);

  state_t             state, state_nx;
  logic [IW-1:0]      ptr, ptr_nx, gnt_idx;
  logic [NUM_REQ-1:0] gnt, sel_oh;
  logic               gnt_any;
  logic               wd_hit;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req     (req_valid),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  assign ptr_nx = (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + IW'(1);

`ifdef DIV_SHARE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wd_cnt;

  // A ready in the limit cycle wins over the watchdog.
  assign wd_hit = (state == ST_WAIT) && !div_ready &&
                  (wd_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt      <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      if (state == ST_LOAD) wd_cnt <= '0;
      else if (state == ST_WAIT && !wd_hit) wd_cnt <= wd_cnt + CW'(1);
      if (state == ST_WAIT && div_ready) rsp_timeout <= 1'b0;
      else if (wd_hit) rsp_timeout <= 1'b1;
    end
  end
`else
  assign wd_hit      = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= ST_IDLE;
      ptr             <= '0;
      sel_oh          <= '0;
      div_dividend    <= '0;
      div_divisor     <= '0;
      rsp_q           <= '0;
      rsp_overflow    <= 1'b0;
      rsp_div_by_zero <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == ST_IDLE && gnt_any) begin
        sel_oh       <= gnt;
        ptr          <= ptr_nx;
        div_dividend <= req_dividend[int'(gnt_idx)*N +: N];
        div_divisor  <= req_divisor[int'(gnt_idx)*N +: N];
      end
      if (state == ST_WAIT) begin
        if (div_ready) begin
          rsp_q           <= div_q;
          rsp_overflow    <= div_overflow;
          rsp_div_by_zero <= div_div_by_zero;
        end else if (wd_hit) begin
          rsp_q           <= '0;
          rsp_overflow    <= 1'b0;
          rsp_div_by_zero <= 1'b0;
        end
      end
    end
  end

  // LOAD never looks at div_ready: it still holds the previous result.
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: if (gnt_any) state_nx = ST_LOAD;
      ST_LOAD: state_nx = ST_WAIT;
      ST_WAIT: if (div_ready || wd_hit) state_nx = ST_RESP;
      ST_RESP: if (|(rsp_ack & sel_oh)) state_nx = ST_IDLE;
    endcase
  end

  assign div_load   = (state == ST_LOAD);
  assign req_accept = (state == ST_LOAD) ? sel_oh : '0;
  assign rsp_valid  = (state == ST_RESP) ? sel_oh : '0;
  assign busy       = (state != ST_IDLE);

endmodule
